// File: rtl/sync_fifo_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo.
// The master drives requests and write data; the slave (the FIFO)
// returns read data and status.
interface sync_fifo_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wr_data_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             full_o;
    logic             empty_o;
    logic             error_o;

    modport master (
        output wr_en, rd_en, wr_data_i,
        input  rd_data_o, full_o, empty_o, error_o
    );

    modport slave (
        input  wr_en, rd_en, wr_data_i,
        output rd_data_o, full_o, empty_o, error_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty flags and a
// one-cycle error strobe on overflow/underflow attempts.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// when the index bits match.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sync_fifo_if.slave     bus
);
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      rd_data_q;
    logic                  error_q;

    logic                  full;
    logic                  empty;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  overflow;
    logic                  underflow;

    // Status decoded straight from the registered pointers.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    // A read frees a slot, so a write into a full FIFO is legal when paired
    // with an accepted read. A read into an empty FIFO never sees the
    // same-cycle write (no read-through).
    assign rd_accept = bus.rd_en && !empty;
    assign wr_accept = bus.wr_en && (!full || rd_accept);
    assign overflow  = bus.wr_en && full && !rd_accept;
    assign underflow = bus.rd_en && empty;

    // Storage array: written on accepted pushes only.
    // NOTE: the memory has no reset; clearing it would forbid RAM inference
    // and nothing reads an entry before it has been written.
    always_ff @(posedge clk_i) begin
        if (rst_i && wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data_i;
        end
    end

    // Pointers, read data and error strobe with synchronous active-low reset.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so ordering of statements here cannot create races.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            error_q <= overflow || underflow;
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.full_o    = full;
    assign bus.empty_o   = empty;
    assign bus.error_o   = error_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, fill, overflow, drain, underflow,
// pointer wrap, simultaneous access at full/empty and mid-run reset.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_sync_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks   = 0;
    int   failures = 0;

    sync_fifo_if #(.WIDTH(WIDTH)) bus ();

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle past it.
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic e, input logic f, input logic err);
        check({tag, ".empty"}, 32'(bus.empty_o), 32'(e));
        check({tag, ".full"},  32'(bus.full_o),  32'(f));
        check({tag, ".error"}, 32'(bus.error_o), 32'(err));
    endtask

    initial begin
        rst_i         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.wr_data_i = '0;

        // Reset held for two edges.
        cycle();
        cycle();
        check_flags("reset", 1'b1, 1'b0, 1'b0);
        check("reset.rd_data", 32'(bus.rd_data_o), 32'h0);
        rst_i = 1'b1;

        // Fill with 0x01..0x10.
        for (int i = 1; i <= DEPTH; i++) begin
            bus.wr_en     = 1'b1;
            bus.wr_data_i = 8'(i);
            cycle();
            check_flags($sformatf("fill%0d", i), 1'b0, (i == DEPTH), 1'b0);
        end

        // Overflow attempt: one-cycle error, still full.
        bus.wr_data_i = 8'hAA;
        cycle();
        bus.wr_en = 1'b0;
        check_flags("overflow", 1'b0, 1'b1, 1'b1);
        cycle();
        check_flags("overflow_clear", 1'b0, 1'b1, 1'b0);

        // Drain; 0xAA must not appear.
        bus.rd_en = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            check($sformatf("drain%0d.data", i), 32'(bus.rd_data_o), 32'(i));
            check_flags($sformatf("drain%0d", i), (i == DEPTH), 1'b0, 1'b0);
        end

        // Underflow: error, data holds last value.
        cycle();
        check_flags("underflow", 1'b1, 1'b0, 1'b1);
        check("underflow.data", 32'(bus.rd_data_o), 32'h10);
        bus.rd_en = 1'b0;
        cycle();
        check("underflow_clear.error", 32'(bus.error_o), 32'h0);

        // Move both pointers to 10 (one word at a time).
        for (int i = 0; i < 10; i++) begin
            bus.wr_en     = 1'b1;
            bus.wr_data_i = 8'(8'h80 + i);
            cycle();
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b1;
            cycle();
            bus.rd_en = 1'b0;
            check($sformatf("pre_wrap%0d.data", i), 32'(bus.rd_data_o), 32'(8'h80 + i));
        end
        check_flags("pre_wrap_empty", 1'b1, 1'b0, 1'b0);

        // Fill across the wrap with 0x20..0x2F.
        bus.wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_data_i = 8'(8'h20 + i);
            cycle();
        end
        check_flags("wrap_full", 1'b0, 1'b1, 1'b0);

        // Simultaneous read/write while full.
        bus.rd_en     = 1'b1;
        bus.wr_data_i = 8'h55;
        cycle();
        bus.wr_en = 1'b0;
        check("full_rw.data", 32'(bus.rd_data_o), 32'h20);
        check_flags("full_rw", 1'b0, 1'b1, 1'b0);

        // Drain: 0x21..0x2F then 0x55.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            check($sformatf("wrap_drain%0d.data", i), 32'(bus.rd_data_o),
                  (i == DEPTH) ? 32'h55 : 32'(8'h20 + i));
        end
        check_flags("wrap_drained", 1'b1, 1'b0, 1'b0);

        // Simultaneous read/write while empty: write only, underflow flagged.
        bus.wr_en     = 1'b1;
        bus.wr_data_i = 8'h66;
        cycle();
        bus.wr_en = 1'b0;
        check_flags("empty_rw", 1'b0, 1'b0, 1'b1);
        check("empty_rw.data", 32'(bus.rd_data_o), 32'h55);
        cycle();
        bus.rd_en = 1'b0;
        check("empty_rw_read.data", 32'(bus.rd_data_o), 32'h66);
        check_flags("empty_rw_read", 1'b1, 1'b0, 1'b0);

        // Reset mid-operation, with a write pending during the reset edge.
        bus.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_data_i = 8'(8'h70 + i);
            cycle();
        end
        check_flags("pre_reset", 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        cycle();
        rst_i     = 1'b1;
        bus.wr_en = 1'b0;
        check_flags("mid_reset", 1'b1, 1'b0, 1'b0);
        check("mid_reset.data", 32'(bus.rd_data_o), 32'h0);
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        check_flags("post_reset_read", 1'b1, 1'b0, 1'b1);
        check("post_reset_read.data", 32'(bus.rd_data_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
